reg_bank: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 25 ++
 rtl/reg_bank_rdport.sv | 69 ++++++
 rtl/reg_bank.sv | 103 ++++++++++
 tb/tb_reg_bank.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults and helpers for the reg_bank register bank.
// Supplies default geometry, the preset fill bit and the clog2 helper used
// to derive address widths.
package reg_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Preset loads every bit of a word with this value unless overridden.
    localparam bit DEFAULT_PRESET_BIT = 1'b1;

    // Smallest n such that 2**n >= value; value is expected to be >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one registered read port of reg_bank.
// Checks the read address against DEPTH, selects the stored word (or zero
// when out of range) and registers it together with a one-cycle valid.
// Optional feature macro: REG_BANK_BYPASS_EN selects write-first forwarding
// of a same-cycle write to the same address; otherwise reads are read-first.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              preset,
    input  logic [WIDTH-1:0]  words [DEPTH],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              out_of_range
);

    logic             in_range;
    logic [WIDTH-1:0] next_data;

    assign in_range     = 32'(rd_addr) < DEPTH;
    assign out_of_range = rd_en && !in_range;

`ifndef REG_BANK_BYPASS_EN
    // Write-side inputs only feed the forwarding path.
    logic unused_wr_port;
    assign unused_wr_port = ^{wr_en, wr_addr, wr_data};
`endif

    // Select the word to capture: stored data, forwarded write data, or zero.
    always_comb begin
        next_data = '0;
        if (in_range) begin
            next_data = words[rd_addr];
`ifdef REG_BANK_BYPASS_EN
            // Equal addresses imply the write is in range as well.
            if (wr_en && (wr_addr == rd_addr)) begin
                next_data = wr_data;
            end
`endif
        end
    end

    // Output register: cleared by either async control, else capture on read.
    always_ff @(posedge clock or negedge reset or negedge preset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (!preset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= next_data;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with one synchronous write port and
// two registered read ports (A, B), async active-low Reset and Preset.
// Optional feature macro: REG_BANK_BYPASS_EN (write-first forwarding in the
// read ports; default build is read-first).
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned           WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned           DEPTH        = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0]      PRESET_VALUE = {WIDTH{DEFAULT_PRESET_BIT}},
    localparam int unsigned          ADDR_W       = clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Preset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    output logic [WIDTH-1:0]  RdDataA,
    output logic              RdValidA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  RdDataB,
    output logic              RdValidB,
    output logic              AddrErr
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_in_range;
    logic             wr_out_of_range;
    logic             rd_out_of_range_a;
    logic             rd_out_of_range_b;

    assign wr_in_range     = 32'(WrAddr) < DEPTH;
    assign wr_out_of_range = WrEn && !wr_in_range;

    // Storage: async clear / preset fill, else write on an in-range strobe.
    always_ff @(posedge Clock or negedge Reset or negedge Preset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!Preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= PRESET_VALUE;
            end
        end else if (WrEn && wr_in_range) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Registered OR of the out-of-range condition over all three ports.
    always_ff @(posedge Clock or negedge Reset or negedge Preset) begin
        if (!Reset) begin
            AddrErr <= 1'b0;
        end else if (!Preset) begin
            AddrErr <= 1'b0;
        end else begin
            AddrErr <= wr_out_of_range | rd_out_of_range_a | rd_out_of_range_b;
        end
    end

    reg_bank_rdport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rdport_a (
        .clock        (Clock),
        .reset        (Reset),
        .preset       (Preset),
        .words        (mem),
        .wr_en        (WrEn),
        .wr_addr      (WrAddr),
        .wr_data      (WrData),
        .rd_en        (RdEnA),
        .rd_addr      (RdAddrA),
        .rd_data      (RdDataA),
        .rd_valid     (RdValidA),
        .out_of_range (rd_out_of_range_a)
    );

    reg_bank_rdport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rdport_b (
        .clock        (Clock),
        .reset        (Reset),
        .preset       (Preset),
        .words        (mem),
        .wr_en        (WrEn),
        .wr_addr      (WrAddr),
        .wr_data      (WrData),
        .rd_en        (RdEnB),
        .rd_addr      (RdAddrB),
        .rd_data      (RdDataB),
        .rd_valid     (RdValidB),
        .out_of_range (rd_out_of_range_b)
    );

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: self-checking bench for reg_bank. Two instances share the
// stimulus: index 0 is DEPTH=8, index 1 is DEPTH=6 (addresses 6 and 7 are
// out of range). Expected values come from a word-array reference model.
module tb_reg_bank;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Preset;
    logic       WrEn;
    logic [2:0] WrAddr;
    logic [7:0] WrData;
    logic       RdEnA;
    logic [2:0] RdAddrA;
    logic       RdEnB;
    logic [2:0] RdAddrB;

    logic [7:0] rd_data_a  [2];
    logic [7:0] rd_data_b  [2];
    logic       rd_valid_a [2];
    logic       rd_valid_b [2];
    logic       addr_err   [2];

    // reference model state
    logic [7:0] mem         [2][8];
    logic [7:0] exp_data_a  [2];
    logic [7:0] exp_data_b  [2];
    logic       exp_valid_a [2];
    logic       exp_valid_b [2];
    logic       exp_err     [2];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    reg_bank #(.WIDTH(8), .DEPTH(8)) u_dut8 (
        .Clock(Clock), .Reset(Reset), .Preset(Preset),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rd_data_a[0]), .RdValidA(rd_valid_a[0]),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rd_data_b[0]), .RdValidB(rd_valid_b[0]),
        .AddrErr(addr_err[0])
    );

    reg_bank #(.WIDTH(8), .DEPTH(6)) u_dut6 (
        .Clock(Clock), .Reset(Reset), .Preset(Preset),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(rd_data_a[1]), .RdValidA(rd_valid_a[1]),
        .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(rd_data_b[1]), .RdValidB(rd_valid_b[1]),
        .AddrErr(addr_err[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic logic [7:0] model_read(input int d, input logic [2:0] addr);
        if (int'(addr) >= depth_of(d)) return 8'h00;
`ifdef REG_BANK_BYPASS_EN
        if (WrEn && (WrAddr == addr)) return WrData;
`endif
        return mem[d][addr];
    endfunction

    // Async Reset/Preset: every word takes fill, all outputs clear.
    task automatic model_fill(input logic [7:0] fill);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mem[d][i] = fill;
            exp_data_a[d]  = 8'h00;
            exp_data_b[d]  = 8'h00;
            exp_valid_a[d] = 1'b0;
            exp_valid_b[d] = 1'b0;
            exp_err[d]     = 1'b0;
        end
    endtask

    // One rising edge worth of behaviour, from the current inputs.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit err;
            err = 1'b0;
            if (RdEnA) begin
                exp_data_a[d]  = model_read(d, RdAddrA);
                exp_valid_a[d] = 1'b1;
                if (int'(RdAddrA) >= depth_of(d)) err = 1'b1;
            end else begin
                exp_valid_a[d] = 1'b0;
            end
            if (RdEnB) begin
                exp_data_b[d]  = model_read(d, RdAddrB);
                exp_valid_b[d] = 1'b1;
                if (int'(RdAddrB) >= depth_of(d)) err = 1'b1;
            end else begin
                exp_valid_b[d] = 1'b0;
            end
            if (WrEn) begin
                if (int'(WrAddr) < depth_of(d)) mem[d][WrAddr] = WrData;
                else err = 1'b1;
            end
            exp_err[d] = err;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        WrEn = 1'b0; WrAddr = '0; WrData = '0;
        RdEnA = 1'b0; RdAddrA = '0;
        RdEnB = 1'b0; RdAddrB = '0;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1; Preset = 1'b1;
        #2;
        Reset = 1'b0; Preset = 1'b0;
        RdEnA = 1'b1; RdEnB = 1'b1;
        model_fill(8'h00);
        repeat (3) @(posedge Clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_valid_a[d] !== 1'b0 || rd_valid_b[d] !== 1'b0 || rd_data_a[d] !== 8'h00 ||
                rd_data_b[d] !== 8'h00 || addr_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold dut%0d: valid=%b/%b data=%h/%h err=%b, expected all zero",
                         d, rd_valid_a[d], rd_valid_b[d], rd_data_a[d], rd_data_b[d], addr_err[d]);
            end
        end
        @(negedge Clock);
        Reset = 1'b1; Preset = 1'b1;
        idle();
        for (int a = 0; a < 8; a++) begin
            RdEnA = 1'b1; RdAddrA = 3'(a);
            RdEnB = 1'b1; RdAddrB = 3'(7 - a);
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd_data_a[d] !== exp_data_a[d] || rd_valid_a[d] !== exp_valid_a[d] ||
                    rd_data_b[d] !== exp_data_b[d] || rd_valid_b[d] !== exp_valid_b[d] ||
                    exp_data_a[d] !== 8'h00 || addr_err[d] !== exp_err[d]) begin
                    errors++;
                    $display("FAIL reset_read dut%0d addr%0d: A=%h/%b B=%h/%b err=%b, expected A=00/%b B=%h/%b err=%b",
                             d, a, rd_data_a[d], rd_valid_a[d], rd_data_b[d], rd_valid_b[d], addr_err[d],
                             exp_valid_a[d], exp_data_b[d], exp_valid_b[d], exp_err[d]);
                end
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle();
        WrEn = 1'b1; WrAddr = 3'd3; WrData = 8'hA5;
        step();
        idle();
        RdEnA = 1'b1; RdAddrA = 3'd3;
        RdEnB = 1'b1; RdAddrB = 3'd3;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_data_a[d] !== 8'hA5 || rd_data_b[d] !== 8'hA5 ||
                rd_valid_a[d] !== 1'b1 || rd_valid_b[d] !== 1'b1) begin
                errors++;
                $display("FAIL write_read dut%0d: A=%h/%b B=%h/%b, expected A5/1 both",
                         d, rd_data_a[d], rd_valid_a[d], rd_data_b[d], rd_valid_b[d]);
            end
        end
        idle();
    endtask

    task automatic test_preset();
        // valid and data are live from the previous read when Preset drops
        Preset = 1'b0;
        #2;
        model_fill(8'hFF);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_valid_a[d] !== 1'b0 || rd_valid_b[d] !== 1'b0 || rd_data_a[d] !== 8'h00 ||
                rd_data_b[d] !== 8'h00 || addr_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL preset_async dut%0d: valid=%b/%b data=%h/%h err=%b, expected all zero",
                         d, rd_valid_a[d], rd_valid_b[d], rd_data_a[d], rd_data_b[d], addr_err[d]);
            end
        end
        @(negedge Clock);
        Preset = 1'b1;
        RdEnA = 1'b1; RdAddrA = 3'd0;
        RdEnB = 1'b1; RdAddrB = 3'd7;
        step();
        checks++;
        if (rd_data_a[0] !== 8'hFF || rd_data_b[0] !== 8'hFF) begin
            errors++;
            $display("FAIL preset_read dut8: A=%h B=%h, expected FF FF", rd_data_a[0], rd_data_b[0]);
        end
        checks++;
        if (rd_data_a[1] !== 8'hFF || rd_data_b[1] !== 8'h00 || addr_err[1] !== 1'b1) begin
            errors++;
            $display("FAIL preset_read dut6: A=%h B=%h err=%b, expected FF 00 1",
                     rd_data_a[1], rd_data_b[1], addr_err[1]);
        end
        // Reset pulse brings the words back to zero
        @(negedge Clock);
        Reset = 1'b0;
        model_fill(8'h00);
        @(negedge Clock);
        Reset = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_data_a[d] !== 8'h00 || rd_data_b[d] !== 8'h00 ||
                rd_valid_a[d] !== 1'b1 || rd_valid_b[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_after_preset dut%0d: A=%h/%b B=%h/%b, expected 00/1 both",
                         d, rd_data_a[d], rd_valid_a[d], rd_data_b[d], rd_valid_b[d]);
            end
        end
        idle();
    endtask

    task automatic test_same_cycle();
        logic [7:0] want;
`ifdef REG_BANK_BYPASS_EN
        want = 8'h3C;
`else
        want = 8'hA5;
`endif
        idle();
        WrEn = 1'b1; WrAddr = 3'd3; WrData = 8'hA5;
        step();
        WrData = 8'h3C;
        RdEnA = 1'b1; RdAddrA = 3'd3;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_data_a[d] !== want || rd_valid_a[d] !== 1'b1) begin
                errors++;
                $display("FAIL same_cycle dut%0d: A=%h/%b, expected %h/1", d, rd_data_a[d], rd_valid_a[d], want);
            end
        end
        WrEn = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_data_a[d] !== 8'h3C) begin
                errors++;
                $display("FAIL same_cycle_next dut%0d: A=%h, expected 3C", d, rd_data_a[d]);
            end
        end
        idle();
    endtask

    task automatic test_out_of_range();
        idle();
        WrEn = 1'b1; WrAddr = 3'd7; WrData = 8'h11;
        RdEnA = 1'b1; RdAddrA = 3'd6;
        step();
        checks++;
        if (rd_data_a[1] !== 8'h00 || rd_valid_a[1] !== 1'b1 || addr_err[1] !== 1'b1) begin
            errors++;
            $display("FAIL oor dut6: A=%h/%b err=%b, expected 00/1 err=1", rd_data_a[1], rd_valid_a[1], addr_err[1]);
        end
        checks++;
        if (rd_data_a[0] !== exp_data_a[0] || addr_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor dut8: A=%h err=%b, expected %h err=0", rd_data_a[0], addr_err[0], exp_data_a[0]);
        end
        idle();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (addr_err[d] !== 1'b0 || rd_valid_a[d] !== 1'b0) begin
                errors++;
                $display("FAIL oor_pulse dut%0d: err=%b valid=%b, expected 0 0", d, addr_err[d], rd_valid_a[d]);
            end
        end
        // no stored word changed in the DEPTH=6 bank
        for (int a = 0; a < 6; a++) begin
            RdEnA = 1'b1; RdAddrA = 3'(a);
            step();
            checks++;
            if (rd_data_a[1] !== exp_data_a[1] || addr_err[1] !== 1'b0) begin
                errors++;
                $display("FAIL oor_nochange dut6 addr%0d: A=%h err=%b, expected %h err=0",
                         a, rd_data_a[1], addr_err[1], exp_data_a[1]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        idle();
        RdEnB = 1'b1; RdAddrB = 3'd3;
        step();
        Reset = 1'b0;
        #2;
        model_fill(8'h00);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_valid_b[d] !== 1'b0 || rd_data_b[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_read dut%0d: B=%h/%b, expected 00/0", d, rd_data_b[d], rd_valid_b[d]);
            end
        end
        idle();
        @(negedge Clock);
        Reset = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_valid_b[d] !== 1'b0 || rd_valid_a[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_stale dut%0d: validA=%b validB=%b, expected 0 0",
                         d, rd_valid_a[d], rd_valid_b[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int n = 0; n < 12; n++) begin
            WrEn = 1'($urandom_range(0, 1)); WrAddr = 3'($urandom_range(0, 5)); WrData = 8'($urandom);
            RdEnA = 1'b1; RdAddrA = 3'($urandom_range(0, 5));
            RdEnB = 1'b1; RdAddrB = 3'($urandom_range(0, 5));
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd_valid_a[d] !== 1'b1 || rd_valid_b[d] !== 1'b1 ||
                    rd_data_a[d] !== exp_data_a[d] || rd_data_b[d] !== exp_data_b[d]) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cyc%0d: A=%h/%b B=%h/%b, expected A=%h/1 B=%h/1",
                             d, n, rd_data_a[d], rd_valid_a[d], rd_data_b[d], rd_valid_b[d],
                             exp_data_a[d], exp_data_b[d]);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            WrEn    = 1'($urandom_range(0, 1));
            WrAddr  = 3'($urandom_range(0, 7));
            WrData  = 8'($urandom);
            RdEnA   = 1'($urandom_range(0, 1));
            RdAddrA = 3'($urandom_range(0, 7));
            RdEnB   = 1'($urandom_range(0, 1));
            RdAddrB = 3'($urandom_range(0, 7));
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd_data_a[d] !== exp_data_a[d] || rd_valid_a[d] !== exp_valid_a[d] ||
                    rd_data_b[d] !== exp_data_b[d] || rd_valid_b[d] !== exp_valid_b[d] ||
                    addr_err[d] !== exp_err[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: A=%h/%b B=%h/%b err=%b, expected A=%h/%b B=%h/%b err=%b",
                             d, n, rd_data_a[d], rd_valid_a[d], rd_data_b[d], rd_valid_b[d], addr_err[d],
                             exp_data_a[d], exp_valid_a[d], exp_data_b[d], exp_valid_b[d], exp_err[d]);
                end
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_write_read();
        test_preset();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
